// File: rtl/btn_debounce.sv
// Pushbutton conditioner: per-bit synchroniser, stability-counter debounce, sticky press flags.
// Optional release flags (released/rel_clr) are built when BTN_RELEASE_EN is defined.
module btn_debounce #(
  parameter int WIDTH       = 4,
  parameter int CNT_BITS    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  input  logic [WIDTH-1:0] ev_clr,
`ifdef BTN_RELEASE_EN
  input  logic [WIDTH-1:0] rel_clr,
  output logic [WIDTH-1:0] released,
`endif
  output logic [WIDTH-1:0] btn_q,
  output logic [WIDTH-1:0] press,
  output logic             ev_any
);

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [CNT_BITS-1:0] cnt_q  [WIDTH];
  logic [WIDTH-1:0]    s;
  logic [WIDTH-1:0]    mism;
  logic [WIDTH-1:0]    term;
  logic [WIDTH-1:0]    flip;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign mism = s ^ btn_q;

  always_comb begin
    term = '0;
    for (int i = 0; i < WIDTH; i++) term[i] = &cnt_q[i];
  end

  // A bit flips only after a full count of uninterrupted mismatch.
  assign flip = mism & term;
  assign rise = flip & s;
  assign fall = flip & ~s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mism[i] || term[i]) cnt_q[i] <= '0;
        else                     cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      press <= '0;
    end else begin
      btn_q <= btn_q ^ flip;
      // Set term listed first so a same-cycle clear cannot drop an event.
      press <= rise | (press & ~ev_clr);
    end
  end

`ifdef BTN_RELEASE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) released <= '0;
    else     released <= fall | (released & ~rel_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ev_any <= 1'b0;
    else     ev_any <= |{press, released};
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ev_any <= 1'b0;
    else     ev_any <= |press;
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with CNT_BITS=4, SYNC_STAGES=2: debounce edge is 18.
module tb_btn_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] ev_clr;
  logic [3:0] btn_q;
  logic [3:0] press;
  logic       ev_any;
`ifdef BTN_RELEASE_EN
  logic [3:0] rel_clr;
  logic [3:0] released;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  btn_debounce #(.WIDTH(4), .CNT_BITS(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .ev_clr  (ev_clr),
`ifdef BTN_RELEASE_EN
    .rel_clr (rel_clr),
    .released(released),
`endif
    .btn_q   (btn_q),
    .press   (press),
    .ev_any  (ev_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges; returns on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'hF;
    ev_clr = 4'h0;
`ifdef BTN_RELEASE_EN
    rel_clr = 4'h0;
`endif
    // 1. reset and first debounce
    step(3);
    chk("rst_btn_q", btn_q, 4'h0);
    chk("rst_press", press, 4'h0);
    chk("rst_ev_any", ev_any, 1'b0);
    rst = 1'b0;
    step(17);
    chk("c1_edge17", btn_q, 4'h0);
    step(1);
    chk("c1_edge18_btn_q", btn_q, 4'hF);
    chk("c1_edge18_press", press, 4'hF);
    chk("c1_edge18_ev_any", ev_any, 1'b0);
    step(1);
    chk("c1_ev_any_lag", ev_any, 1'b1);
    ev_clr = 4'hF;
    step(1);
    ev_clr = 4'h0;
    chk("c1_clr_press", press, 4'h0);
    step(1);
    chk("c1_clr_ev_any", ev_any, 1'b0);

    // 2. bounce on bit 0
    btn_in = 4'h0;
    step(20);
    chk("c2_fall_btn_q", btn_q, 4'h0);
    chk("c2_fall_no_press", press, 4'h0);
    for (int k = 0; k < 8; k++) begin
      btn_in[0] = (k % 2 == 0);
      for (int j = 0; j < 5; j++) begin
        step(1);
        chk("c2_bounce_hold", btn_q[0], 1'b0);
      end
    end
    btn_in[0] = 1'b1;
    step(17);
    chk("c2_edge17", btn_q[0], 1'b0);
    step(1);
    chk("c2_edge18", btn_q[0], 1'b1);
    chk("c2_press", press, 4'h1);
    ev_clr = 4'h1;
    step(1);
    ev_clr = 4'h0;

    // 3. clear racing the set
    btn_in = 4'h3;
    step(17);
    chk("c3_edge17", btn_q, 4'h1);
    ev_clr = 4'h2;
    step(1);
    ev_clr = 4'h0;
    chk("c3_race_btn_q", btn_q, 4'h3);
    chk("c3_race_press", press, 4'h2);
    step(1);
    chk("c3_race_ev_any", ev_any, 1'b1);
    ev_clr = 4'h2;
    step(1);
    ev_clr = 4'h0;
    chk("c3_lone_clr_press", press, 4'h0);
    step(1);
    chk("c3_lone_clr_ev_any", ev_any, 1'b0);

    // 4. reset in the middle of a count
    rst    = 1'b1;
    btn_in = 4'h0;
    step(2);
    rst = 1'b0;
    step(1);
    btn_in = 4'h1;
    step(10);
    chk("c4_pre_rst", btn_q, 4'h0);
    rst = 1'b1;
    step(1);
    chk("c4_in_rst_btn_q", btn_q, 4'h0);
    chk("c4_in_rst_press", press, 4'h0);
    rst = 1'b0;
    for (int j = 0; j < 17; j++) begin
      step(1);
      chk("c4_no_early_rise", btn_q, 4'h0);
    end
    step(1);
    chk("c4_edge18_btn_q", btn_q, 4'h1);
    chk("c4_edge18_press", press, 4'h1);

    // 5. independent bits, fall does not touch press
    rst    = 1'b1;
    btn_in = 4'h0;
    step(2);
    rst    = 1'b0;
    btn_in = 4'h5;
    step(30);
    chk("c5_btn_q_5", btn_q, 4'h5);
    chk("c5_press_5", press, 4'h5);
    chk("c5_ev_any", ev_any, 1'b1);
`ifdef BTN_RELEASE_EN
    chk("c6_no_release_yet", released, 4'h0);
`endif
    btn_in = 4'h4;
    step(17);
    chk("c5_fall_edge17", btn_q, 4'h5);
    step(1);
    chk("c5_fall_edge18", btn_q, 4'h4);
    chk("c5_press_kept", press, 4'h5);
`ifdef BTN_RELEASE_EN
    // 6. release flags
    chk("c6_released", released, 4'h1);
    step(1);
    chk("c6_ev_any", ev_any, 1'b1);
    ev_clr = 4'h5;
    step(1);
    ev_clr = 4'h0;
    chk("c6_press_clr", press, 4'h0);
    step(1);
    chk("c6_ev_any_rel_only", ev_any, 1'b1);
    rel_clr = 4'h1;
    step(1);
    rel_clr = 4'h0;
    chk("c6_rel_clr", released, 4'h0);
    step(1);
    chk("c6_ev_any_clr", ev_any, 1'b0);
`else
    step(1);
    chk("c5_ev_any_after_fall", ev_any, 1'b1);
    ev_clr = 4'h5;
    step(1);
    ev_clr = 4'h0;
    chk("c5_press_clr", press, 4'h0);
    step(1);
    chk("c5_ev_any_clr", ev_any, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
